// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default widths,
// and the round-robin pointer advance.
package dmem_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side request/response bundle plus the shared memory port of the arbiter.
// The slave modport is the arbiter's view; master is the cores-plus-memory side.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int AW     = DMEM_AW,
  parameter int DW     = DMEM_DW
);
  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    we;
  logic [NCORES*AW-1:0] addr;
  logic [NCORES*DW-1:0] wdata;
  logic [NCORES-1:0]    gnt;
  logic [NCORES-1:0]    done;
  logic [DW-1:0]        rdata;

  logic                 mem_en;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at index >= ptr,
// wrapping modulo NCORES. Returns one-hot grant, binary index and valid.
module rr_pick #(
  parameter int NCORES = 4,
  parameter int PW     = $clog2(NCORES)
) (
  input  logic [NCORES-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NCORES-1:0] gnt,
  output logic [PW-1:0]     idx,
  output logic              valid
);
  logic [2*NCORES-1:0] req2;
  logic [NCORES-1:0]   rot;
  logic [PW-1:0]       off;
  logic [PW:0]         sum;

  // Doubling the vector turns the wrap-around scan into a plain lowest-bit search.
  assign req2 = {req, req};
  assign rot  = req2[ptr +: NCORES];

  always_comb begin
    off   = '0;
    valid = 1'b0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = PW'(k);
        valid = 1'b1;
      end
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= (PW+1)'(NCORES)) ? PW'(sum - (PW+1)'(NCORES)) : PW'(sum);

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_onehot
      assign gnt[gi] = valid && (idx == PW'(gi));
    end
  endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data-memory port among NCORES cores.
// One transaction at a time: IDLE (pick) -> ACCESS (MEM_LAT cycles) -> RESP (done pulse).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NCORES  = 4,
  parameter int AW      = DMEM_AW,
  parameter int DW      = DMEM_DW,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam int PW = $clog2(NCORES);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [AW-1:0] core_addr  [NCORES];
  logic [DW-1:0] core_wdata [NCORES];

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_unpack
      assign core_addr[gi]  = bus.addr[gi*AW +: AW];
      assign core_wdata[gi] = bus.wdata[gi*DW +: DW];
    end
  endgenerate

  dmem_state_t       state_reg;
  logic [PW-1:0]     ptr_reg;
  logic [PW-1:0]     sel_reg;
  logic [CW-1:0]     cnt_reg;
  logic              we_reg;
  logic [NCORES-1:0] gnt_reg;
  logic [NCORES-1:0] done_reg;
  logic [DW-1:0]     rdata_reg;
  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [AW-1:0]     mem_addr_reg;
  logic [DW-1:0]     mem_wdata_reg;

  logic [NCORES-1:0] pick_gnt;
  logic [PW-1:0]     pick_idx;
  logic              pick_valid;

  rr_pick #(
    .NCORES(NCORES),
    .PW    (PW)
  ) u_pick (
    .req  (bus.req),
    .ptr  (ptr_reg),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      sel_reg       <= '0;
      cnt_reg       <= '0;
      we_reg        <= 1'b0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      rdata_reg     <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // The memory-port registers double as the request latch for the whole access.
          if (pick_valid) begin
            sel_reg       <= pick_idx;
            we_reg        <= bus.we[pick_idx];
            gnt_reg       <= pick_gnt;
            mem_en_reg    <= 1'b1;
            mem_we_reg    <= bus.we[pick_idx];
            mem_addr_reg  <= core_addr[pick_idx];
            mem_wdata_reg <= core_wdata[pick_idx];
            cnt_reg       <= CW'(MEM_LAT - 1);
            state_reg     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we_reg <= 1'b0;
          if (cnt_reg == '0) begin
            mem_en_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if (!we_reg) begin
              rdata_reg <= bus.mem_rdata;
            end
            done_reg  <= gnt_reg;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        RESP: begin
          done_reg  <= '0;
          gnt_reg   <= '0;
          rdata_reg <= '0;
          ptr_reg   <= PW'(rr_next(int'(sel_reg), NCORES));
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.done      = done_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int NCORES  = 4;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.NCORES(NCORES), .AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(
    .NCORES (NCORES),
    .AW     (AW),
    .DW     (DW),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 'h10) return 8'hA5;
    return DW'((a * 7 + 3) & 'hFF);
  endfunction

  // Synchronous RAM with one registered read stage: data valid in the last access cycle.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_load) for (int k = 0; k < 256; k++) ram[k] <= init_val(k);
    if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (rst) ram_q <= '0;
    else if (bus.mem_en) ram_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = ram_q;

  // Reference model: one transaction at a time, tracked by its age since grant.
  logic [DW-1:0] ref_mem [256];
  bit            m_busy;
  int            m_age, m_core, m_ptr, pick, cyc;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  initial begin
    m_busy = 0; m_age = 0; m_core = 0; m_ptr = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; cyc = 0; pick = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (mem_load) for (int k = 0; k < 256; k++) ref_mem[k] = init_val(k);
      if (m_busy && m_age == 1 && m_we) ref_mem[m_addr] = m_wdata;
      if (rst) begin
        m_busy = 0; m_age = 0; m_ptr = 0;
      end else if (!m_busy) begin
        for (int k = 0; k < NCORES; k++) begin
          pick = (m_ptr + k) % NCORES;
          if (!m_busy && bus.req[pick]) begin
            m_busy  = 1;
            m_core  = pick;
            m_age   = 1;
            m_we    = bus.we[pick];
            m_addr  = bus.addr[pick*AW +: AW];
            m_wdata = bus.wdata[pick*DW +: DW];
          end
        end
      end else if (m_age == MEM_LAT + 1) begin
        m_busy = 0;
        m_ptr  = (m_core + 1) % NCORES;
      end else begin
        m_age++;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int onehot_idx(input logic [NCORES-1:0] v);
    for (int i = 0; i < NCORES; i++) if (v[i]) return i;
    return -1;
  endfunction

  bit                check_en = 0;
  logic [NCORES-1:0] done_prev = '0;
  logic [NCORES-1:0] gnt_prev  = '0;
  int                done_core [$];
  logic [DW-1:0]     done_rd   [$];
  int                done_cyc  [$];
  int                gnt_core  [$];
  int                we_cnt = 0;
  logic [AW-1:0]     we_addr = '0;
  logic [DW-1:0]     we_data = '0;
  int                addr_hits [256];

  // Monitor and per-cycle compare against the model, sampled mid-cycle.
  initial begin
    logic [NCORES-1:0] e_gnt, e_done;
    logic [DW-1:0]     e_rdata;
    bit                acc, resp;
    for (int k = 0; k < 256; k++) addr_hits[k] = 0;
    forever begin
      @(negedge clk);
      done_prev = bus.done;
      if (check_en) begin
        if (|bus.done) begin
          done_core.push_back(onehot_idx(bus.done));
          done_rd.push_back(bus.rdata);
          done_cyc.push_back(cyc);
        end
        if (bus.gnt != '0 && gnt_prev == '0) gnt_core.push_back(onehot_idx(bus.gnt));
        gnt_prev = bus.gnt;
        if (bus.mem_en && bus.mem_we) begin
          we_cnt++; we_addr = bus.mem_addr; we_data = bus.mem_wdata;
        end
        if (bus.mem_en) addr_hits[bus.mem_addr]++;

        acc  = m_busy && (m_age <= MEM_LAT);
        resp = m_busy && (m_age == MEM_LAT + 1);
        e_gnt = '0;
        if (m_busy) e_gnt[m_core] = 1'b1;
        e_done  = resp ? e_gnt : '0;
        e_rdata = (resp && !m_we) ? ref_mem[m_addr] : '0;
        chk("gnt",       32'(bus.gnt),       32'(e_gnt));
        chk("done",      32'(bus.done),      32'(e_done));
        chk("rdata",     32'(bus.rdata),     32'(e_rdata));
        chk("mem_en",    32'(bus.mem_en),    32'(acc));
        chk("mem_we",    32'(bus.mem_we),    32'(m_busy && m_age == 1 && m_we));
        chk("mem_addr",  32'(bus.mem_addr),  acc ? 32'(m_addr) : 32'd0);
        chk("mem_wdata", 32'(bus.mem_wdata), acc ? 32'(m_wdata) : 32'd0);
      end
    end
  end

  // Each step also releases any core whose done was seen in the previous cycle.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.req = bus.req & ~done_prev;
    end
  endtask

  task automatic set_core(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we[c]               = w;
    bus.addr[c*AW +: AW]    = a;
    bus.wdata[c*DW +: DW]   = d;
    bus.req[c]              = 1'b1;
  endtask

  task automatic wait_quiet(input string name, input int max_cyc);
    int n;
    n = 0;
    while (n < max_cyc && !(bus.req == '0 && bus.gnt == '0 && bus.done == '0)) begin
      tick(1);
      n++;
    end
    chk(name, {28'd0, bus.req | bus.gnt}, 32'd0);
  endtask

  int order3 [5];
  int order4 [2];
  int base_g, base_d, base_we, base_h5, base_h6;

  initial begin
    order3[0] = 0; order3[1] = 1; order3[2] = 2; order3[3] = 3; order3[4] = 0;
    order4[0] = 0; order4[1] = 2;
    rst = 1'b1; mem_load = 1'b1;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    @(posedge clk);
    #1;
    mem_load = 1'b0;
    check_en = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("reset_gnt",    32'(bus.gnt),    32'd0);
    chk("reset_mem_en", 32'(bus.mem_en), 32'd0);
    chk("reset_rdata",  32'(bus.rdata),  32'd0);

    // Single read by core1.
    set_core(1, 1'b0, 8'h10, 8'h00);
    tick(1);
    chk("t1_gnt", 32'(bus.gnt), 32'b0010);
    tick(MEM_LAT);
    chk("t1_done",  32'(bus.done),  32'b0010);
    chk("t1_rdata", 32'(bus.rdata), 32'hA5);
    wait_quiet("t1_quiet", 20);

    // Single write by core0, then read back by core3.
    base_we = we_cnt;
    set_core(0, 1'b1, 8'h20, 8'h3C);
    wait_quiet("t2_quiet", 20);
    chk("t2_we_pulses", 32'(we_cnt - base_we), 32'd1);
    chk("t2_we_addr",   32'(we_addr), 32'h20);
    chk("t2_we_data",   32'(we_data), 32'h3C);
    chk("t2_done_core", 32'(done_core[$]), 32'd0);
    set_core(3, 1'b0, 8'h20, 8'h00);
    wait_quiet("t2b_quiet", 20);
    chk("t2_rd_core",  32'(done_core[$]), 32'd3);
    chk("t2_rd_rdata", 32'(done_rd[$]),   32'h3C);

    // Contention from reset; core0 re-requests right after its done.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    base_g = gnt_core.size();
    base_d = done_cyc.size();
    for (int k = 0; k < NCORES; k++) set_core(k, 1'b0, AW'(8'h30 + k), 8'h00);
    tick(MEM_LAT + 2);
    set_core(0, 1'b0, 8'h40, 8'h00);
    wait_quiet("t3_quiet", 60);
    chk("t3_grants", 32'(gnt_core.size() - base_g), 32'd5);
    for (int i = 0; i < 5; i++)
      if (base_g + i < gnt_core.size()) chk("t3_order", 32'(gnt_core[base_g + i]), 32'(order3[i]));
    for (int i = 1; i < 5; i++)
      if (base_d + i < done_cyc.size())
        chk("t3_spacing", 32'(done_cyc[base_d + i] - done_cyc[base_d + i - 1]), 32'(MEM_LAT + 2));

    // Wrap-around: core2 alone leaves ptr at 3, then cores 0 and 2 together.
    set_core(2, 1'b0, 8'h50, 8'h00);
    wait_quiet("t4a_quiet", 20);
    base_g = gnt_core.size();
    set_core(0, 1'b0, 8'h51, 8'h00);
    set_core(2, 1'b0, 8'h52, 8'h00);
    wait_quiet("t4_quiet", 40);
    chk("t4_grants", 32'(gnt_core.size() - base_g), 32'd2);
    for (int i = 0; i < 2; i++)
      if (base_g + i < gnt_core.size()) chk("t4_order", 32'(gnt_core[base_g + i]), 32'(order4[i]));

    // Inputs changed and req dropped mid-access: the latched request still completes.
    base_h5 = addr_hits[5];
    base_h6 = addr_hits[6];
    base_d  = done_core.size();
    set_core(2, 1'b0, 8'h05, 8'h00);
    tick(1);
    bus.addr[2*AW +: AW] = 8'h06;
    bus.req[2] = 1'b0;
    wait_quiet("t5_quiet", 20);
    chk("t5_hits_05", 32'(addr_hits[5] - base_h5), 32'(MEM_LAT));
    chk("t5_hits_06", 32'(addr_hits[6] - base_h6), 32'd0);
    chk("t5_dones",   32'(done_core.size() - base_d), 32'd1);
    chk("t5_core",    32'(done_core[$]), 32'd2);
    chk("t5_rdata",   32'(done_rd[$]),   32'h26);

    // Reset during the second access cycle abandons the transaction.
    base_d = done_core.size();
    set_core(1, 1'b0, 8'h10, 8'h00);
    tick(2);
    rst = 1'b1;
    bus.req = '0;
    tick(1);
    chk("t6_gnt",    32'(bus.gnt),    32'd0);
    chk("t6_mem_en", 32'(bus.mem_en), 32'd0);
    chk("t6_done",   32'(bus.done),   32'd0);
    rst = 1'b0;
    tick(2);
    chk("t6_no_done", 32'(done_core.size() - base_d), 32'd0);
    set_core(3, 1'b0, 8'h20, 8'h00);
    tick(1);
    chk("t6_gnt3", 32'(bus.gnt), 32'b1000);
    wait_quiet("t6_quiet", 20);
    chk("t6_rdata", 32'(done_rd[$]), 32'h3C);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
